// File: rtl/mem_rdata_unpack.sv
// mem_rdata_unpack: accepts 256-bit AXI4 read beats into a small FIFO and
// serialises each beat into OUT_WIDTH-bit words (least-significant word first)
// on a valid/ready stream. Tracks accepted beats, sticky error and done flags,
// and marks the last word of a programmed transfer length.
module mem_rdata_unpack #(
    parameter int DATA_WIDTH  = 256,
    parameter int OUT_WIDTH   = 32,
    parameter int ID_WIDTH    = 1,
    parameter int RUSER_WIDTH = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   clear_i,
    input  logic [CNT_WIDTH-1:0]   expected_beats_i,
    input  logic [ID_WIDTH-1:0]    s_axi_rid_i,
    input  logic [DATA_WIDTH-1:0]  s_axi_rdata_i,
    input  logic [1:0]             s_axi_rresp_i,
    input  logic                   s_axi_rlast_i,
    input  logic [RUSER_WIDTH-1:0] s_axi_ruser_i,
    input  logic                   s_axi_rvalid_i,
    output logic                   s_axi_rready_o,
    output logic [OUT_WIDTH-1:0]   m_data_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic                   m_last_o,
    output logic [CNT_WIDTH-1:0]   beat_count_o,
    output logic                   err_o,
    output logic                   done_o
);

    localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(RATIO - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]     IDX_ZERO = IDX_W'(0);
    localparam logic [PTR_W:0]       PTR_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]       PTR_ZERO = (PTR_W + 1)'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   beat_q, beat_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_WIDTH-1:0]    popped_q, popped_d;
    logic [CNT_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic [PTR_W:0]          wptr_q, wptr_d;
    logic [PTR_W:0]          rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];

    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [DATA_WIDTH-1:0]   fifo_rdata_s;
    logic                    rready_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    hold_s;
    logic                    m_last_s;
    logic                    unused_s;

    // Sideband fields carry no information for single-beat bursts.
    assign unused_s = ^{s_axi_rid_i, s_axi_rlast_i, s_axi_ruser_i};

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty_s = (wptr_q == rptr_q);
    assign fifo_full_s  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                          (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign fifo_rdata_s = mem_q[rptr_q[PTR_W-1:0]];

    // Ready is held low while in reset so nothing is accepted before the block is up.
    assign rready_s = !fifo_full_s && !clear_i && reset_n_i;
    assign push_s   = s_axi_rvalid_i && rready_s;
    assign hold_s   = (state_q == ST_HOLD);
    assign m_last_s = hold_s && (idx_q == IDX_LAST) &&
                      (popped_q == expected_beats_i) && (expected_beats_i != CNT_ZERO);

    assign s_axi_rready_o = rready_s;
    assign m_valid_o      = hold_s;
    assign m_data_o       = hold_s ? beat_q[OUT_WIDTH*int'(idx_q) +: OUT_WIDTH]
                                   : {OUT_WIDTH{1'b0}};
    assign m_last_o       = m_last_s;
    assign beat_count_o   = beat_cnt_q;
    assign err_o          = err_q;
    assign done_o         = done_q;

    // Next-state logic: unpack sequencing, FIFO pointers, counters and sticky flags.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        idx_d      = idx_q;
        popped_d   = popped_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        done_d     = done_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        pop_s      = 1'b0;

        if (clear_i) begin
            state_d    = ST_EMPTY;
            idx_d      = IDX_ZERO;
            popped_d   = CNT_ZERO;
            beat_cnt_d = CNT_ZERO;
            err_d      = 1'b0;
            done_d     = 1'b0;
            wptr_d     = PTR_ZERO;
            rptr_d     = PTR_ZERO;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (!fifo_empty_s) begin
                        pop_s = 1'b1;
                    end else begin
                        pop_s = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (m_ready_i) begin
                        if (m_last_s) begin
                            done_d = 1'b1;
                        end else begin
                            done_d = done_q;
                        end
                        // Last word of a beat chains straight into the next beat when one is waiting.
                        if (idx_q != IDX_LAST) begin
                            idx_d = idx_q + IDX_ONE;
                        end else if (!fifo_empty_s) begin
                            pop_s = 1'b1;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end else begin
                        idx_d = idx_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase

            if (pop_s) begin
                state_d = ST_HOLD;
                beat_d  = fifo_rdata_s;
                idx_d   = IDX_ZERO;
                rptr_d  = rptr_q + PTR_ONE;
                // Saturate so extra beats past the transfer never re-match expected_beats_i by wrapping.
                if (popped_q != CNT_MAX) begin
                    popped_d = popped_q + CNT_ONE;
                end else begin
                    popped_d = popped_q;
                end
            end else begin
                rptr_d = rptr_q;
            end

            if (push_s) begin
                wptr_d     = wptr_q + PTR_ONE;
                beat_cnt_d = beat_cnt_q + CNT_ONE;
                if (s_axi_rresp_i != 2'b00) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end else begin
                wptr_d = wptr_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_EMPTY;
            beat_q     <= {DATA_WIDTH{1'b0}};
            idx_q      <= IDX_ZERO;
            popped_q   <= CNT_ZERO;
            beat_cnt_q <= CNT_ZERO;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            wptr_q     <= PTR_ZERO;
            rptr_q     <= PTR_ZERO;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            idx_q      <= idx_d;
            popped_q   <= popped_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wptr_q[PTR_W-1:0]] <= s_axi_rdata_i;
        end
    end

endmodule
